// File: rtl/data_memory_responder.sv
// Data-memory responder: services one CPU load/store at a time from an internal
// word array, with programmable wait states and a 4-phase request/ready handshake.
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 18,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  memLoad,
  input  logic                  memStore,
  input  logic [ADDR_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] storeData,
  output logic [DATA_WIDTH-1:0] loadData,
  output logic                  memReady,
  output logic                  busy,
  output logic                  accessError,
  output logic [1:0]            debugState
);

  // Handshake: memLoad/memStore are levels held by the requester until memReady
  // pulses for one cycle; the requester must then drop both before a new request
  // is accepted (the responder sits in RELEASE until it sees them low).

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACCESS  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t state, nextState;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [3:0]            waitCount;
  logic                  capLoad, capStore;
  logic [ADDR_WIDTH-1:0] capAddr;
  logic [DATA_WIDTH-1:0] capData;

  logic                  reqAny, capture, enterAccess;
  logic                  opLoad, opStore, badBoth, badAddr, opError, writeEn;
  logic [ADDR_WIDTH-1:0] opAddr;
  logic [DATA_WIDTH-1:0] opData, readWord;
  logic [IDX_W-1:0]      opIdx;

  assign reqAny = memLoad | memStore;

  // With zero wait states the access happens on the capture edge itself, so the
  // operation is taken straight from the inputs while idle.
  always_comb begin
    opLoad  = capLoad;
    opStore = capStore;
    opAddr  = capAddr;
    opData  = capData;
    if (state == S_IDLE) begin
      opLoad  = memLoad;
      opStore = memStore;
      opAddr  = memAddr;
      opData  = storeData;
    end
  end

  assign badBoth  = opLoad & opStore;
  assign badAddr  = 32'(opAddr) >= DEPTH;
  assign opError  = badBoth | badAddr;
  assign opIdx    = opAddr[IDX_W-1:0];
  assign readWord = mem[opIdx];
  assign writeEn  = enterAccess & opStore & ~opError & resetN;

  always_comb begin
    nextState   = state;
    capture     = 1'b0;
    enterAccess = 1'b0;
    case (state)
      S_IDLE: begin
        if (reqAny) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            nextState   = S_ACCESS;
            enterAccess = 1'b1;
          end else begin
            nextState = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (waitCount == 4'd1) begin
          nextState   = S_ACCESS;
          enterAccess = 1'b1;
        end
      end
      S_ACCESS:  nextState = S_RELEASE;
      S_RELEASE: if (!reqAny) nextState = S_IDLE;
      default:   nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state       <= S_IDLE;
      waitCount   <= 4'd0;
      capLoad     <= 1'b0;
      capStore    <= 1'b0;
      capAddr     <= '0;
      capData     <= '0;
      loadData    <= '0;
      accessError <= 1'b0;
    end else begin
      state <= nextState;
      if (capture) begin
        capLoad     <= memLoad;
        capStore    <= memStore;
        capAddr     <= memAddr;
        capData     <= storeData;
        waitCount   <= 4'(WAIT_CYCLES);
        accessError <= 1'b0;
      end else if (state == S_WAIT) begin
        waitCount <= waitCount - 4'd1;
      end
      // A conflicting request leaves loadData alone; an out-of-range load returns 0.
      if (enterAccess) begin
        accessError <= opError;
        if (opLoad && !badBoth) begin
          loadData <= badAddr ? '0 : readWord;
        end
      end
    end
  end

  // Array contents survive reset, so the storage has no reset term.
  always_ff @(posedge clock) begin
    if (writeEn) begin
      mem[opIdx] <= opData;
    end
  end

  assign memReady   = (state == S_ACCESS);
  assign busy       = (state != S_IDLE);
  assign debugState = state;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a 2-wait-state instance and a 0-wait-state
// instance, directed scenarios plus random traffic against an array model.
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        resetN;
  logic [1:0]  ldV, stV;
  logic [13:0] addrV [2];
  logic [17:0] dataV [2];
  logic [17:0] loadV [2];
  logic [1:0]  rdyV, busyV, errV;
  logic [1:0]  dbgV [2];

  logic [17:0] model [2][1024];
  bit          known [2][1024];
  logic [17:0] expLoad [2];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.WAIT_CYCLES(2)) dut (
    .clock(clock), .resetN(resetN), .memLoad(ldV[0]), .memStore(stV[0]),
    .memAddr(addrV[0]), .storeData(dataV[0]), .loadData(loadV[0]),
    .memReady(rdyV[0]), .busy(busyV[0]), .accessError(errV[0]), .debugState(dbgV[0])
  );

  data_memory_responder #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .resetN(resetN), .memLoad(ldV[1]), .memStore(stV[1]),
    .memAddr(addrV[1]), .storeData(dataV[1]), .loadData(loadV[1]),
    .memReady(rdyV[1]), .busy(busyV[1]), .accessError(errV[1]), .debugState(dbgV[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete handshake on instance s; expectations come from the array model.
  task automatic req(input int s, input logic ld, input logic st, input logic [13:0] a,
                     input logic [17:0] d, input int hold);
    int   cyc;
    int   lat;
    logic both, oor, err;
    lat  = (s == 0) ? 2 : 0;
    both = ld & st;
    oor  = (a >= 14'd1024);
    err  = both | oor;
    if (!err && st) begin
      model[s][a[9:0]] = d;
      known[s][a[9:0]] = 1'b1;
    end
    if (ld && !both) expLoad[s] = oor ? 18'd0 : model[s][a[9:0]];

    @(negedge clock);
    ldV[s] = ld; stV[s] = st; addrV[s] = a; dataV[s] = d;
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
      // Scramble address/data mid-wait: the captured copy must be used.
      if (!rdyV[s] && cyc == 1) begin
        addrV[s] = 14'($urandom);
        dataV[s] = 18'($urandom);
      end
    end while (!rdyV[s] && cyc < 30);
    check($sformatf("latency[%0d]", s), cyc, lat + 1);
    check($sformatf("ready[%0d]", s), rdyV[s], 1'b1);
    check($sformatf("busy_ready[%0d]", s), busyV[s], 1'b1);
    check($sformatf("err[%0d] a=%0d", s, a), errV[s], err);
    check($sformatf("loadData[%0d] a=%0d", s, a), loadV[s], expLoad[s]);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      check($sformatf("held_ready[%0d]", s), rdyV[s], 1'b0);
      check($sformatf("held_busy[%0d]", s), busyV[s], 1'b1);
    end
    ldV[s] = 1'b0; stV[s] = 1'b0;
    if (hold == 0) begin
      @(negedge clock);
      check($sformatf("release_ready[%0d]", s), rdyV[s], 1'b0);
      check($sformatf("release_busy[%0d]", s), busyV[s], 1'b1);
    end
    @(negedge clock);
    check($sformatf("idle_busy[%0d]", s), busyV[s], 1'b0);
    check($sformatf("idle_ready[%0d]", s), rdyV[s], 1'b0);
  endtask

  initial begin
    int pulses;
    resetN = 1'b0;
    ldV = '0; stV = '0;
    for (int s = 0; s < 2; s++) begin
      addrV[s] = '0; dataV[s] = '0; expLoad[s] = '0;
    end

    // Clock/reset
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("rst_loadData[%0d]", s), loadV[s], 18'd0);
      check($sformatf("rst_ready[%0d]", s), rdyV[s], 1'b0);
      check($sformatf("rst_busy[%0d]", s), busyV[s], 1'b0);
      check($sformatf("rst_err[%0d]", s), errV[s], 1'b0);
    end
    resetN = 1'b1;
    @(negedge clock);

    // Store then load back
    req(0, 1'b0, 1'b1, 14'd5, 18'h2ABCD, 0);
    req(0, 1'b1, 1'b0, 14'd5, 18'h0, 0);

    // Out-of-range accesses; 976 aliases 2000 in the low address bits
    req(0, 1'b0, 1'b1, 14'd976, 18'h1234, 0);
    req(0, 1'b1, 1'b0, 14'd1024, 18'h0, 0);
    req(0, 1'b0, 1'b1, 14'd2000, 18'h3F00F, 0);
    req(0, 1'b1, 1'b0, 14'd976, 18'h0, 0);

    // Conflicting load+store
    req(0, 1'b0, 1'b1, 14'd7, 18'h00777, 0);
    req(0, 1'b1, 1'b0, 14'd5, 18'h0, 0);
    req(0, 1'b1, 1'b1, 14'd7, 18'h15555, 0);
    req(0, 1'b1, 1'b0, 14'd7, 18'h0, 0);

    // Request held long after ready
    req(0, 1'b1, 1'b0, 14'd5, 18'h0, 10);

    // Reset during WAIT drops the pending store
    req(0, 1'b0, 1'b1, 14'd9, 18'h0ABCD, 0);
    @(negedge clock);
    ldV[0] = 1'b0; stV[0] = 1'b1; addrV[0] = 14'd9; dataV[0] = 18'h3FFFF;
    @(negedge clock);
    check("wait_busy", busyV[0], 1'b1);
    resetN = 1'b0;
    #1;
    check("midrst_ready", rdyV[0], 1'b0);
    check("midrst_busy", busyV[0], 1'b0);
    check("midrst_loadData", loadV[0], 18'd0);
    check("midrst_err", errV[0], 1'b0);
    expLoad[0] = '0;
    expLoad[1] = '0;
    @(negedge clock);
    stV[0] = 1'b0;
    resetN = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clock);
      if (rdyV[0]) pulses++;
    end
    check("midrst_no_ready", pulses, 0);
    req(0, 1'b1, 1'b0, 14'd9, 18'h0, 0);

    // Zero-wait instance: boundary addresses back to back
    req(1, 1'b0, 1'b1, 14'd0, 18'h11111, 0);
    req(1, 1'b0, 1'b1, 14'd1023, 18'h2EEEE, 0);
    req(1, 1'b1, 1'b0, 14'd0, 18'h0, 0);
    req(1, 1'b1, 1'b0, 14'd1023, 18'h0, 0);
    req(1, 1'b1, 1'b0, 14'd1024, 18'h0, 0);

    // Random traffic on both instances
    for (int n = 0; n < 60; n++) begin
      int          s, kind;
      logic [13:0] a;
      logic [17:0] d;
      s    = (n < 40) ? 0 : 1;
      kind = $urandom_range(0, 9);
      a    = ($urandom_range(0, 3) == 0) ? 14'(1008 + $urandom_range(0, 15))
                                         : 14'($urandom_range(0, 15));
      d    = 18'($urandom);
      case (kind)
        0: req(s, 1'b1, 1'b1, a, d, $urandom_range(0, 2));
        1: req(s, 1'b1, 1'b0, 14'(1024 + $urandom_range(0, 15000)), d, $urandom_range(0, 2));
        2: req(s, 1'b0, 1'b1, 14'(1024 + $urandom_range(0, 15000)), d, $urandom_range(0, 2));
        3, 4, 5: req(s, 1'b0, 1'b1, a, d, $urandom_range(0, 2));
        default: begin
          if (known[s][a[9:0]]) req(s, 1'b1, 1'b0, a, d, $urandom_range(0, 2));
          else                  req(s, 1'b0, 1'b1, a, d, $urandom_range(0, 2));
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
